// File: rtl/sram_controller.sv
// sram_controller: splits a 32-bit MEM-stage access into two 16-bit SRAM half-accesses.
module sram_controller #(
   parameter int ACCESS_CYCLES = 2,
   parameter int BASE_ADDR     = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);
   localparam int CW = $clog2(ACCESS_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic op_wr, op_wr_nx;
   logic [31:0] offs;
   logic [16:0] w;
   logic last, act, drv;
   logic unused_offs;
   assign offs = address - 32'(BASE_ADDR);
   assign w = offs[18:2];
   assign unused_offs = &{1'b0, offs[31:19], offs[1:0]};
   assign last = cnt == CW'(ACCESS_CYCLES - 1);
   assign act = state == LOW || state == HIGH;
   assign drv = act && op_wr;
   assign ready = state == DONE || (state == IDLE && !wr_en && !rd_en);
   assign SRAM_WE_N = !drv;
   assign SRAM_OE_N = drv;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_ADDR = act ? {w, state == HIGH} : 18'd0;
   assign SRAM_DQ = drv ? (state == HIGH ? write_data[31:16] : write_data[15:0]) : 16'bz;
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      op_wr_nx = op_wr;
      case (state)
         IDLE: if (wr_en || rd_en) begin
            state_nx = LOW;
            cnt_nx = '0;
            op_wr_nx = wr_en;
         end
         LOW: begin
            cnt_nx = last ? '0 : cnt + CW'(1);
            state_nx = last ? HIGH : LOW;
         end
         HIGH: begin
            cnt_nx = last ? '0 : cnt + CW'(1);
            state_nx = last ? DONE : HIGH;
         end
         default: state_nx = IDLE;
      endcase
   end
   // each half is captured on the final cycle it is held on the bus
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         op_wr <= 1'b0;
         read_data <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         op_wr <= op_wr_nx;
         if (act && !op_wr && last) begin
            if (state == LOW) read_data[15:0] <= SRAM_DQ;
            else read_data[31:16] <= SRAM_DQ;
         end
      end
   end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle memory-stage controller that turns the single-cycle 32-bit data-memory request from the EXE/MEM pipeline register into two sequential 16-bit accesses on an external asynchronous SRAM. It sits in the MEM stage, directly downstream of EXE. Its `ready` output freezes every pipeline register, so the MEM_dest/MEM_WB_en values seen by the forwarding unit stay stable for the whole access. Read data is returned as a registered 32-bit word for the MEM/WB register.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: cycles each 16-bit half-access is held on the SRAM pins; legal range ≥ 1.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: store request from EXE/MEM register; held stable while `ready`=0.
- `rd_en` input 1: load request; held stable while `ready`=0.
- `address` input 32: byte address, word aligned.
- `write_data` input 32: store data.
- `read_data` output 32: registered load result.
- `ready` output 1: 1 means the pipeline may advance this cycle.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output 18: SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` output 1 each: active-low SRAM controls.

## Operation
- Address map:
  - word index `w = (address − BASE_ADDR) >> 2`, 32-bit subtract, low 17 bits kept;
  - low half at `SRAM_ADDR = {w[16:0],1'b0}`, high half at `{w[16:0],1'b1}`.
- Tied controls: `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` are constant 0.
- FSM states are IDLE, LOW, HIGH and DONE.
  - IDLE: if `wr_en` or `rd_en` is set, latch the op (write wins if both are set) and go to LOW with the counter cleared. Otherwise stay in IDLE.
  - LOW: drive the low-half address. Stay for ACCESS_CYCLES cycles using a counter of width `$clog2(ACCESS_CYCLES+1)`, then go to HIGH with the counter cleared.
  - HIGH: drive the high-half address for ACCESS_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- Write op, during LOW and HIGH:
  - `SRAM_WE_N`=0 and `SRAM_OE_N`=1;
  - `SRAM_DQ` driven with `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH.
- Read op:
  - `SRAM_WE_N`=1, `SRAM_OE_N`=0, `SRAM_DQ` high-Z.
  - `SRAM_DQ` is sampled into `read_data[15:0]` on the last LOW cycle and into `read_data[31:16]` on the last HIGH cycle.
- `SRAM_DQ` is high-Z in every state except LOW/HIGH of a write.
- `read_data` is updated only by reads and holds its value through writes and idle periods.
- `ready` is combinational:
  - 1 in IDLE when `wr_en`=`rd_en`=0;
  - 0 in IDLE with a request, and in LOW and HIGH;
  - 1 in DONE.

## Timing
- Reset values:
  - state IDLE, counter 0, `read_data` = 0;
  - `SRAM_WE_N`=1, `SRAM_OE_N`=0, `SRAM_DQ` high-Z, `SRAM_ADDR` = 0;
  - `ready` = 1 when no request is present.
- Stall length: a request first seen in IDLE at cycle 0 holds `ready` low for cycles 0 … 2·ACCESS_CYCLES. `ready` is 1 in cycle 2·ACCESS_CYCLES+1 (DONE).
- With ACCESS_CYCLES=2, `ready` goes high at cycle 5, and the pipeline advances on the edge ending that cycle.
- `read_data` is valid throughout DONE and afterwards.
- Back-to-back memory ops: after DONE the FSM spends one IDLE cycle with `ready`=0 before the next LOW. There is no stale re-issue, because the pipeline advanced at the DONE edge.
- `rst` asserted in any state: at the next edge the FSM returns to IDLE, `SRAM_WE_N`=1, `SRAM_DQ` is released and `read_data` is cleared. A partial write may leave one SRAM half updated; this is accepted.
- Request inputs that change while `ready`=0 violate the protocol. The latched op type governs; address and data are taken live.

## Test plan
- Reset, then idle: `rst`=1 for 2 cycles → `ready`=1, `read_data`=0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z.
- Write 0xDEADBEEF to address 1024 (ACCESS_CYCLES=2):
  - `SRAM_ADDR`=0 with DQ=0xBEEF and `SRAM_WE_N`=0 for 2 cycles;
  - then `SRAM_ADDR`=1 with DQ=0xDEAD for 2 cycles;
  - `ready`=1 exactly at cycle 5.
- Read back from address 1024 with an SRAM model → `read_data`=0xDEADBEEF in DONE, `SRAM_OE_N`=0, DQ never driven by the DUT.
- Address 1032 → `SRAM_ADDR` = 4, then 5.
- Back-to-back: a read of 1028 followed immediately by a write to 1036 → two full sequences with one IDLE gap cycle. `read_data` is unchanged by the write.
- Reset mid-access: `rst` asserted in the first HIGH cycle of a write → next cycle IDLE, `SRAM_WE_N`=1, DQ high-Z, `read_data`=0. A new read then completes in 2·ACCESS_CYCLES+1 cycles.
